game_timer_bcd: RTL and testbench
=================================

Name: game_timer_bcd

Overview:
Parameterised multi-digit BCD game timer with an internal prescaler and selectable tick rate. Counts down from a loaded value to 0, or up from 0 to a loaded limit. Supports start, pause/resume and reload, and flags expiry with a one-cycle pulse. Its digit bus feeds the 7-segment decoders directly, and the game FSM uses Expired to end a round.

Parameters:
CLOCK_FREQUENCY, 50000000, ClockIn cycles per 1x tick (must be ≥8)
DIGITS, 2, number of BCD digits (1..8)
WARN_SECONDS, 10, warning threshold in binary seconds (used only with TIMER_WARN_EN)

Ports:
ClockIn  in  1  system clock
Reset  in  1  synchronous, active-high reset
Load  in  1  pulse; capture LoadValue and Down, enter IDLE
LoadValue  in  4*DIGITS  BCD; start value (down mode) or limit (up mode)
Down  in  1  mode sampled on Load: 1=count down, 0=count up
Start  in  1  pulse; IDLE/PAUSE -> RUN
Pause  in  1  pulse; RUN -> PAUSE
Speed  in  2  tick rate = 2^Speed ticks per CLOCK_FREQUENCY cycles
BcdDigits  out  4*DIGITS  current value; digit 0 in [3:0]
Running  out  1  high in RUN
Expired  out  1  one-cycle pulse on reaching terminal value
Done  out  1  level, high in DONE
Warning  out  1  see Optional Feature (tied 0 when disabled)

Behaviour:
- States: IDLE, RUN, PAUSE, DONE. Reset -> IDLE.
- Reset values: BcdDigits=0, limit=0, mode=down, prescaler=0, Running=0, Expired=0, Done=0, Warning=0.
- Command priority within one cycle: Reset > Load > Start > Pause > tick.
- Load, any state:
  - Down=1: value=LoadValue, terminal=0.
  - Down=0: value=0, terminal=LoadValue.
  - Any LoadValue digit >9 is clamped to 9.
  - Prescaler is reloaded; state -> IDLE.
- Start:
  - IDLE/PAUSE -> RUN.
  - If value already equals terminal on Start, go directly to DONE with an Expired pulse the next cycle.
  - Ignored in RUN and DONE.
- Pause: RUN -> PAUSE. Prescaler holds its count; on resume it continues from the held count. Ignored in other states.
- Prescaler:
  - Down-counter reloaded with (CLOCK_FREQUENCY>>Speed)-1.
  - Decrements only in RUN; tick is a one-cycle internal pulse when it reaches 0, then it reloads.
  - First tick after Start from IDLE arrives exactly CLOCK_FREQUENCY>>Speed cycles after Start.
  - A Speed change takes effect at the next reload.
- Tick in RUN: value ±1 in BCD.
  - Digit carry: 9 -> 0 with carry; borrow: 0 -> 9 with borrow.
  - Carry/borrow ripples across all DIGITS in the same cycle.
- Terminal:
  - The tick that makes value==terminal moves the state to DONE.
  - Expired=1 for exactly one cycle, coincident with the first cycle BcdDigits shows the terminal value. Done=1 from that same cycle.
  - No wrap-around: value is frozen in DONE until Load or Reset.
- Running and Done are registered state decodes. Latency from a command pulse to the output change is 1 cycle.
- Reset mid-count: everything returns to reset values on the next edge; a pending tick is discarded.

Optional Feature:
Macro TIMER_WARN_EN.
- Defined: Warning=1 while in RUN or PAUSE, mode=down, and value ≤ WARN_SECONDS (compared in BCD, i.e. against WARN_SECONDS converted to BCD at elaboration). Warning is 0 in IDLE and DONE, and registered with the same timing as BcdDigits.
- Undefined: Warning tied to 0 and no comparator is generated.

Test Plan:
- CLOCK_FREQUENCY=8, DIGITS=2, Speed=0: Load 0x05 Down=1, Start -> value 0x04 at cycle 8 after Start, then 0x03, 0x02, 0x01, 0x00 every 8 cycles. Expired pulses once with value 0x00; Done=1; value stays 0x00 for 50 more cycles.
- Up mode: Load 0x12 Down=0, Start, Speed=3 (tick every cycle) -> value 0x00..0x09, then 0x10 (carry), 0x11, 0x12. Expired and Done at 0x12, no 0x13.
- Borrow ripple: Load 0x100 (DIGITS=3) Down=1, Speed=3, Start -> next value 0x099, then 0x098.
- Pause/resume: with CLOCK_FREQUENCY=8, Pause 3 cycles after a tick, hold 20 cycles, Start -> next decrement arrives 5 cycles after resume; Running low during the hold.
- Simultaneous events: Load and Start asserted in the same cycle -> Load wins (IDLE, value=LoadValue). Start with loaded value 0x00 Down=1 -> Done next cycle plus a single Expired. Reset during RUN -> all outputs 0 next cycle.
- TIMER_WARN_EN defined, WARN_SECONDS=10: count down from 0x12 -> Warning rises when value=0x10, stays high through 0x01, and falls when Done asserts.

Source files
------------

// File: rtl/game_timer_bcd.sv
// Multi-digit BCD game timer: prescaled tick, count down to 0 or up to a limit.
// Optional TIMER_WARN_EN adds a registered low-time Warning output in down mode.
module game_timer_bcd #(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned DIGITS          = 2,
    parameter int unsigned WARN_SECONDS    = 10
) (
    input  logic                  ClockIn,
    input  logic                  Reset,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadValue,
    input  logic                  Down,
    input  logic                  Start,
    input  logic                  Pause,
    input  logic [1:0]            Speed,
    output logic [4*DIGITS-1:0]   BcdDigits,
    output logic                  Running,
    output logic                  Expired,
    output logic                  Done,
    output logic                  Warning
);

    localparam int unsigned VW = 4 * DIGITS;
    localparam int unsigned PW = $clog2(CLOCK_FREQUENCY);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic [VW-1:0]  r_value, w_value_nxt;
    logic [VW-1:0]  r_limit, w_limit_nxt;
    logic           r_down, w_down_nxt;
    logic [PW-1:0]  r_presc, w_presc_nxt;
    logic           r_expired, w_expired_nxt;
    logic           r_running, r_done;
    logic [PW-1:0]  w_reload;
    logic [VW-1:0]  w_step;

    // Force any non-decimal digit to 9
    function automatic logic [VW-1:0] bcd_clamp(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // One BCD increment/decrement with carry/borrow rippling through all digits
    function automatic logic [VW-1:0] bcd_step(input logic [VW-1:0] v, input logic up);
        logic [VW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (up) begin
                    if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                    else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                    else begin
                        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign w_reload = PW'((CLOCK_FREQUENCY >> Speed) - 32'd1);
    assign w_step   = bcd_step(r_value, ~r_down);

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_value   <= '0;
            r_limit   <= '0;
            r_down    <= 1'b1;
            r_presc   <= '0;
            r_expired <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_value   <= w_value_nxt;
            r_limit   <= w_limit_nxt;
            r_down    <= w_down_nxt;
            r_presc   <= w_presc_nxt;
            r_expired <= w_expired_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    // Command priority Load > Start > Pause > tick
    always_comb begin
        w_state_nxt   = r_state;
        w_value_nxt   = r_value;
        w_limit_nxt   = r_limit;
        w_down_nxt    = r_down;
        w_presc_nxt   = r_presc;
        w_expired_nxt = 1'b0;
        if (Load) begin
            w_down_nxt  = Down;
            w_value_nxt = Down ? bcd_clamp(LoadValue) : '0;
            w_limit_nxt = Down ? '0 : bcd_clamp(LoadValue);
            w_presc_nxt = w_reload;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_PAUSE: begin
                    if (Start) begin
                        if (r_value == r_limit) begin
                            w_state_nxt   = S_DONE;
                            w_expired_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_RUN;
                            if (r_state == S_IDLE) w_presc_nxt = w_reload;
                        end
                    end
                end
                S_RUN: begin
                    // The Pause cycle still counts as running; a due tick waits for resume
                    if (Pause) begin
                        w_state_nxt = S_PAUSE;
                        if (r_presc != '0) w_presc_nxt = r_presc - PW'(1);
                    end else if (r_presc == '0) begin
                        w_presc_nxt = w_reload;
                        w_value_nxt = w_step;
                        if (w_step == r_limit) begin
                            w_state_nxt   = S_DONE;
                            w_expired_nxt = 1'b1;
                        end
                    end else begin
                        w_presc_nxt = r_presc - PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign BcdDigits = r_value;
    assign Running   = r_running;
    assign Expired   = r_expired;
    assign Done      = r_done;

`ifdef TIMER_WARN_EN
    // Threshold as BCD; saturates to all-ones if it exceeds the digit count
    function automatic logic [VW-1:0] to_bcd(input int unsigned n);
        logic [VW-1:0] r;
        int unsigned   rem;
        r   = '0;
        rem = n;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem         = rem / 10;
        end
        if (rem != 0) r = '1;
        return r;
    endfunction

    localparam logic [VW-1:0] WARN_BCD = to_bcd(WARN_SECONDS);

    logic r_warning;

    always_ff @(posedge ClockIn) begin
        if (Reset) r_warning <= 1'b0;
        else       r_warning <= ((w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE)) &&
                                w_down_nxt && (w_value_nxt <= WARN_BCD);
    end

    assign Warning = r_warning;
`else
    assign Warning = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer_bcd.sv
// Self-checking bench for game_timer_bcd: per-cycle vector table plus timed sequences.
module tb_game_timer_bcd;

    localparam int unsigned CF = 8;
    localparam int unsigned DG = 3;
    localparam int unsigned VW = 4 * DG;
`ifdef TIMER_WARN_EN
    localparam bit WARN_ON = 1'b1;
`else
    localparam bit WARN_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, load, down, start, pause;
    logic [1:0]    speed;
    logic [VW-1:0] lv;
    logic [VW-1:0] bcd;
    logic          running, expired, done, warning;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          rst, load, start, pause, down;
        logic [1:0]    speed;
        logic [VW-1:0] lv;
        logic [VW-1:0] e_val;
        logic          e_run, e_exp, e_done, e_warn;
    } vec_t;

    vec_t vecs[$];

    game_timer_bcd #(.CLOCK_FREQUENCY(CF), .DIGITS(DG), .WARN_SECONDS(10)) dut (
        .ClockIn(clk), .Reset(rst), .Load(load), .LoadValue(lv), .Down(down),
        .Start(start), .Pause(pause), .Speed(speed), .BcdDigits(bcd),
        .Running(running), .Expired(expired), .Done(done), .Warning(warning)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, l, s, p, d, input logic [1:0] spd, input logic [VW-1:0] v,
                       input logic [VW-1:0] ev, input logic er, ee, ed, ew);
        vec_t t;
        t.rst = r; t.load = l; t.start = s; t.pause = p; t.down = d; t.speed = spd; t.lv = v;
        t.e_val = ev; t.e_run = er; t.e_exp = ee; t.e_done = ed; t.e_warn = ew;
        vecs.push_back(t);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmds();
        rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    // Cycles until BcdDigits changes, capped at 40
    task automatic wait_change(output int n);
        logic [VW-1:0] old;
        old = bcd;
        n = 0;
        while ((bcd == old) && (n < 40)) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pulses, moved;
        clear_cmds();
        down = 1'b0; speed = 2'd0; lv = '0;

        // Up mode, tick every cycle (Speed=3 -> reload 0)
        add(1,0,0,0,0,2'd0,12'h000, 12'h000,0,0,0,0);
        add(0,1,0,0,0,2'd3,12'h012, 12'h000,0,0,0,0);
        add(0,0,1,0,0,2'd3,12'h000, 12'h000,1,0,0,0);
        for (int k = 1; k <= 11; k++)
            add(0,0,0,0,0,2'd3,12'h000, 12'(((k / 10) << 4) | (k % 10)),1,0,0,0);
        add(0,0,0,0,0,2'd3,12'h000, 12'h012,0,1,1,0);
        add(0,0,0,0,0,2'd3,12'h000, 12'h012,0,0,1,0);
        add(0,0,1,0,0,2'd3,12'h000, 12'h012,0,0,1,0);
        // Load beats Start; clamping; start at terminal
        add(0,1,1,0,1,2'd3,12'h005, 12'h005,0,0,0,0);
        add(0,1,0,0,1,2'd3,12'h0AF, 12'h099,0,0,0,0);
        add(0,1,0,0,1,2'd3,12'h000, 12'h000,0,0,0,0);
        add(0,0,1,0,0,2'd3,12'h000, 12'h000,0,1,1,0);
        add(0,0,0,0,0,2'd3,12'h000, 12'h000,0,0,1,0);
        // Borrow ripple, then reset mid-run
        add(0,1,0,0,1,2'd3,12'h100, 12'h100,0,0,0,0);
        add(0,0,1,0,0,2'd3,12'h000, 12'h100,1,0,0,0);
        add(0,0,0,0,0,2'd3,12'h000, 12'h099,1,0,0,0);
        add(0,0,0,0,0,2'd3,12'h000, 12'h098,1,0,0,0);
        add(1,0,0,0,0,2'd3,12'h000, 12'h000,0,0,0,0);
        // Warning threshold crossing, held through pause
        add(0,1,0,0,1,2'd3,12'h012, 12'h012,0,0,0,0);
        add(0,0,1,0,0,2'd3,12'h000, 12'h012,1,0,0,0);
        add(0,0,0,0,0,2'd3,12'h000, 12'h011,1,0,0,0);
        add(0,0,0,0,0,2'd3,12'h000, 12'h010,1,0,0,1);
        add(0,0,0,0,0,2'd3,12'h000, 12'h009,1,0,0,1);
        add(0,0,0,1,0,2'd3,12'h000, 12'h009,0,0,0,1);
        add(0,0,1,0,0,2'd3,12'h000, 12'h009,1,0,0,1);
        add(0,0,0,0,0,2'd3,12'h000, 12'h008,1,0,0,1);
        add(1,0,0,0,0,2'd3,12'h000, 12'h000,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; load = vecs[i].load; start = vecs[i].start;
            pause = vecs[i].pause; down = vecs[i].down; speed = vecs[i].speed; lv = vecs[i].lv;
            cyc();
            chk($sformatf("vec%0d value", i), 32'(bcd), 32'(vecs[i].e_val));
            chk($sformatf("vec%0d running", i), 32'(running), 32'(vecs[i].e_run));
            chk($sformatf("vec%0d expired", i), 32'(expired), 32'(vecs[i].e_exp));
            chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].e_done));
            chk($sformatf("vec%0d warning", i), 32'(warning), 32'(vecs[i].e_warn & WARN_ON));
        end
        clear_cmds();

        // Down count from 5 at 1x: one step every 8 cycles
        speed = 2'd0; down = 1'b1; lv = 12'h005; load = 1'b1;
        cyc();
        clear_cmds();
        start = 1'b1;
        cyc();
        clear_cmds();
        chk("down start running", 32'(running), 32'd1);
        chk("down start warning", 32'(warning), 32'(WARN_ON));
        for (int k = 4; k >= 1; k--) begin
            wait_change(n);
            chk($sformatf("down gap to %0d", k), 32'(n), 32'd8);
            chk($sformatf("down value %0d", k), 32'(bcd), 32'(k));
            chk($sformatf("down expired at %0d", k), 32'(expired), 32'd0);
            chk($sformatf("down warning at %0d", k), 32'(warning), 32'(WARN_ON));
        end
        wait_change(n);
        chk("down gap to 0", 32'(n), 32'd8);
        chk("down final value", 32'(bcd), 32'h000);
        chk("down final expired", 32'(expired), 32'd1);
        chk("down final done", 32'(done), 32'd1);
        chk("down final running", 32'(running), 32'd0);
        chk("down final warning", 32'(warning), 32'd0);
        pulses = 0; moved = 0;
        repeat (50) begin
            cyc();
            if (expired) pulses++;
            if (bcd != 12'h000) moved++;
        end
        chk("done extra expired pulses", 32'(pulses), 32'd0);
        chk("done value moved", 32'(moved), 32'd0);
        chk("done held", 32'(done), 32'd1);

        // Pause 3 cycles after a tick, hold 20, resume: next step 5 cycles later
        down = 1'b1; lv = 12'h009; load = 1'b1;
        cyc();
        clear_cmds();
        start = 1'b1;
        cyc();
        clear_cmds();
        wait_change(n);
        chk("pause first gap", 32'(n), 32'd8);
        chk("pause first value", 32'(bcd), 32'h008);
        cyc();
        cyc();
        pause = 1'b1;
        cyc();
        clear_cmds();
        chk("pause running low", 32'(running), 32'd0);
        moved = 0; pulses = 0;
        repeat (20) begin
            cyc();
            if (running) pulses++;
            if (bcd != 12'h008) moved++;
        end
        chk("pause hold running", 32'(pulses), 32'd0);
        chk("pause hold value", 32'(moved), 32'd0);
        start = 1'b1;
        cyc();
        clear_cmds();
        chk("resume running", 32'(running), 32'd1);
        wait_change(n);
        chk("resume gap", 32'(n), 32'd5);
        chk("resume value", 32'(bcd), 32'h007);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
